// File: rtl/sqrt_pkg.sv
// Shared types and constants for the square-root arbiter slice.
package sqrt_pkg;

  localparam int unsigned SQRT_IN_W  = 32;
  localparam int unsigned SQRT_OUT_W = 24;
  localparam int unsigned SQRT_LAT   = 24;
  localparam int unsigned ID_W       = 3;
  localparam int unsigned MAX_REQ    = 1 << ID_W;

  // Job sequencer states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_BUSY  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

  // Response payload returned to the requesters
  typedef struct packed {
    logic [ID_W-1:0]       id;
    logic [SQRT_OUT_W-1:0] result;
    logic                  error;
  } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, cyclically.
module rr_arbiter
  import sqrt_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt_c,
  output logic [ID_W-1:0]  idx_c,
  output logic             any_c
);

  localparam int unsigned SUM_W = ID_W + 1;

  logic [MAX_REQ-1:0] req_pad;
  logic [SUM_W-1:0]   slot;
  logic               found;

  assign req_pad = MAX_REQ'(req);
  assign any_c   = |req;

  // Cyclic priority search starting at the pointer
  always_comb begin
    idx_c = '0;
    found = 1'b0;
    slot  = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      slot = {1'b0, ptr} + SUM_W'(i);
      if (slot >= SUM_W'(N_REQ)) slot = slot - SUM_W'(N_REQ);
      if (!found && req_pad[slot[ID_W-1:0]]) begin
        found = 1'b1;
        idx_c = slot[ID_W-1:0];
      end
    end
  end

  assign gnt_c = any_c ? (N_REQ'(1) << idx_c) : '0;

endmodule

// File: rtl/sqrt_arbiter.sv
// Shares one CORDIC sqrt core between N_REQ requesters with round-robin
// arbitration, a per-job watchdog and a tagged response register.
module sqrt_arbiter
  import sqrt_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = SQRT_LAT + 16,
  parameter int unsigned ERR_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [SQRT_IN_W*N_REQ-1:0] req_operand,
  output logic [N_REQ-1:0]           ack,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [SQRT_OUT_W-1:0]      rsp_result,
  output logic                       rsp_error,
  output logic                       busy,
  output logic [ERR_W-1:0]           err_count,
  output logic                       sq_start,
  output logic [SQRT_IN_W-1:0]       sq_operand,
  input  logic [SQRT_OUT_W-1:0]      sq_result,
  input  logic                       sq_stop
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT);

  state_t                 state;
  state_t                 state_nx;
  logic [TMR_W-1:0]       timer;
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        job_id;
  rsp_t                   rsp_q;
  logic [SQRT_IN_W-1:0]   ops [MAX_REQ];

  logic [N_REQ-1:0]       gnt_c;
  logic [ID_W-1:0]        gnt_idx_c;
  logic                   any_c;
  logic                   grant_c;
  logic                   done_c;
  logic                   tmo_c;
  logic                   xfer_c;

  // Unpack operand slices; unused slots tie to zero so the 3-bit id indexes cleanly
  for (genvar g = 0; g < int'(MAX_REQ); g++) begin : g_ops
    if (g < int'(N_REQ)) begin : g_used
      assign ops[g] = req_operand[SQRT_IN_W*g +: SQRT_IN_W];
    end else begin : g_pad
      assign ops[g] = '0;
    end
  end

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .req   (req),
    .ptr   (rr_ptr),
    .gnt_c (gnt_c),
    .idx_c (gnt_idx_c),
    .any_c (any_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state and job event decode
  always_comb begin
    state_nx = state;
    grant_c  = 1'b0;
    done_c   = 1'b0;
    tmo_c    = 1'b0;
    xfer_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_c) begin
          grant_c  = 1'b1;
          state_nx = ST_START;
        end
      end
      ST_START: state_nx = ST_BUSY;
      ST_BUSY: begin
        // Stale done from the previous job is ignored in the first BUSY cycle
        if (timer != '0 && sq_stop) begin
          done_c   = 1'b1;
          state_nx = ST_RESP;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          tmo_c    = 1'b1;
          state_nx = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          xfer_c   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Watchdog: counts BUSY cycles, cleared during START
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 timer <= '0;
    else if (state == ST_START) timer <= '0;
    else if (state == ST_BUSY)  timer <= timer + TMR_W'(1);
  end

  // Grant, core drive, response capture and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack        <= '0;
      sq_start   <= 1'b0;
      sq_operand <= '0;
      job_id     <= '0;
      rr_ptr     <= '0;
      rsp_valid  <= 1'b0;
      rsp_q      <= '0;
      err_count  <= '0;
      busy       <= 1'b0;
    end else begin
      ack      <= '0;
      sq_start <= 1'b0;
      busy     <= (state_nx != ST_IDLE);
      if (grant_c) begin
        ack        <= gnt_c;
        sq_start   <= 1'b1;
        sq_operand <= ops[gnt_idx_c];
        job_id     <= gnt_idx_c;
      end
      if (done_c) begin
        rsp_valid    <= 1'b1;
        rsp_q.id     <= job_id;
        rsp_q.result <= sq_result;
        rsp_q.error  <= 1'b0;
      end
      if (tmo_c) begin
        rsp_valid    <= 1'b1;
        rsp_q.id     <= job_id;
        rsp_q.result <= '0;
        rsp_q.error  <= 1'b1;
        if (err_count != '1) err_count <= err_count + ERR_W'(1);
      end
      if (xfer_c) begin
        rsp_valid <= 1'b0;
        rr_ptr    <= (job_id == ID_W'(N_REQ - 1)) ? '0 : job_id + ID_W'(1);
      end
    end
  end

  assign rsp_id     = rsp_q.id;
  assign rsp_result = rsp_q.result;
  assign rsp_error  = rsp_q.error;

endmodule

// File: doc/sqrt_arbiter.md
Name: sqrt_arbiter

Overview:
- Shares one CORDIC square-root datapath between N_REQ requesters using round-robin arbitration.
- Sequences the datapath per job: one-cycle start/init, wait for done, capture result, return it tagged with the requester id.
- A watchdog aborts any job whose done never arrives, returning an error response instead of hanging the shared unit.
- Sits between the requesting processing elements and the sqrt core.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT, 40, max BUSY cycles before abort (must exceed the core's 24-cycle run)
ERR_W, 8, width of the saturating fault counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester request level; held with operand until ack
req_operand  in  32*N_REQ  flattened operands, slice i = bits [32i+31:32i]
ack  out  N_REQ  one-cycle pulse: request i accepted, operand captured
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  3  index of requester owning the response
rsp_result  out  24  square root (core format: result^2 >> 16 = operand)
rsp_error  out  1  response produced by timeout; rsp_result = 0
busy  out  1  a job is in flight (state != IDLE)
err_count  out  ERR_W  number of timeouts since reset, saturating
sq_start  out  1  start/init to the sqrt core
sq_operand  out  32  operand to the sqrt core
sq_result  in  24  core result
sq_stop  in  1  core done level

Behaviour:
- Reset (async, rst_n=0): state IDLE, all outputs 0, round-robin pointer = 0, timer = 0, err_count = 0. Takes effect immediately, including mid-job. The core is re-initialised by the next job's start.
- FSM states: IDLE, START, BUSY, RESP.
- IDLE, req != 0:
  - Grant the first set req bit at or after rr_ptr, searching cyclically.
  - Latch the operand slice and id into registers.
  - Next state START.
  - IDLE with req == 0 stays IDLE.
- START, exactly 1 cycle:
  - sq_start = 1; sq_operand = latched operand (held stable the whole cycle, so the core's negedge capture is safe).
  - ack[id] = 1 in this cycle only.
  - timer cleared. Next state BUSY.
- BUSY:
  - sq_start = 0; sq_operand held; timer increments each cycle.
  - sq_stop is not sampled in the first BUSY cycle; the core's stale done is cleared by the start.
  - sq_stop = 1 (from the second BUSY cycle on): register sq_result into rsp_result, rsp_error = 0, go RESP.
  - Else, timer == TIMEOUT-1: rsp_result = 0, rsp_error = 1, err_count += 1 (saturating at all-ones), go RESP.
  - If sq_stop and timeout coincide, the valid result wins: no error.
- With the team core: 24 BUSY cycles; rsp_valid first high 25 cycles after the START cycle.
- RESP:
  - rsp_valid = 1; rsp_id, rsp_result and rsp_error stable while rsp_ready = 0.
  - rsp_valid & rsp_ready: rr_ptr = (id + 1) mod N_REQ, go IDLE.
  - New requests are not accepted during START, BUSY or RESP; one job in flight at a time.
- Back-to-back jobs: IDLE → START takes 1 cycle, so the minimum job period is 1 + BUSY + RESP + 1 cycles.
- A requester dropping req before ack has no effect once it has been granted; its latched operand is still processed.
- Width rules:
  - rsp_id zero-extended to 3 bits.
  - Operand passed unmodified.
  - No arithmetic on results.

Decomposition:
- Shared package sqrt_pkg holds:
  - state enum (IDLE, START, BUSY, RESP);
  - constants SQRT_IN_W = 32, SQRT_OUT_W = 24, SQRT_LAT = 24;
  - the id width.
- One natural sub-module: rr_arbiter (N_REQ request vector + pointer in → one-hot grant + encoded index out, combinational).
- The FSM, watchdog and response registers stay in sqrt_arbiter.

Test Plan:
- The bench uses a behavioural sqrt core with the same handshake (done 24 cycles after start); a fault-mode variant never raises sq_stop.
1. Single request: req[0]=1, operand 0x00010000 → ack[0] in START cycle; 25 cycles later rsp_valid=1, rsp_id=0, rsp_result=0x010000, rsp_error=0.
2. Round-robin: req = 4'b1111 held, operands 4/16/64/256 → grants in order 0,1,2,3,0; results 0x000200, 0x000400, 0x000800, 0x001000.
3. Backpressure: rsp_ready=0 for 10 cycles after rsp_valid → outputs stable, no ack issued; rsp_ready=1 → IDLE next cycle, next grant follows.
4. Timeout: fault-mode core, req[2]=1 → rsp_valid after TIMEOUT BUSY cycles with rsp_error=1, rsp_result=0, rsp_id=2, err_count=1; the following job on a healthy core succeeds.
5. Reset mid-BUSY: assert rst_n=0 for 1 cycle at BUSY cycle 10 → all outputs 0 immediately, err_count=0, rr_ptr=0; pending req[1] is granted after release.
6. Simultaneous done and timeout: core done forced at timer=TIMEOUT-1 → rsp_error=0, result captured, err_count unchanged.
